wb_write_serializer: RTL and testbench

- Write-back end of the register-file write port: drives WB_data / WB_address / write_enable into instruction_decode.
- Accepts up to two register writes per cycle from the MEM/WB stage (e.g. SWAP writes Rs and Rd, POP writes data).
- Serializes them onto the single write port through a small FIFO, with valid/ready backpressure towards MEM/WB.

---
 rtl/wb_write_serializer.sv | 143 ++++++++++++++
 tb/tb_wb_write_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_serializer.sv
// wb_write_serializer: write-back end of the register-file write port.
//
// Takes up to two register writes per cycle from MEM/WB (slot 0 before slot 1), drops slots
// whose write enable is low, and serializes the rest onto the single register-file write port
// through a DEPTH-entry FIFO. Backpressure towards MEM/WB is given by in_ready.
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   in_valid / in_ready        write-bundle handshake (accept on in_valid && in_ready)
//   in_we0/addr0/data0         slot-0 write request
//   in_we1/addr1/data1         slot-1 write request
//   WB_data / WB_address       register-file write data / address
//   write_enable               register-file write strobe, at most one write per cycle
//   pending                    number of entries currently stored in the FIFO
//
// Optional feature macro: WB_BYPASS_EN
//   Defined:   a write offered while nothing is stored or being written goes straight to the
//              outputs combinationally in the accepting cycle (slot 0 of a dual write only).
//   Undefined: all outputs are registered, one cycle after acceptance.
module wb_write_serializer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_we0,
  input  logic [ADDR_W-1:0]        in_addr0,
  input  logic [DATA_W-1:0]        in_data0,
  input  logic                     in_we1,
  input  logic [ADDR_W-1:0]        in_addr1,
  input  logic [DATA_W-1:0]        in_data1,
  output logic [DATA_W-1:0]        WB_data,
  output logic [ADDR_W-1:0]        WB_address,
  output logic                     write_enable,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_inc;
  logic [CW-1:0] count_q, count_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic          accept, acc0, acc1, fifo_empty, bypass;
  logic [1:0]    n_acc, st_n;
  logic [EW-1:0] first, second, head, st_a, st_b;
  logic          pop_fifo, pop_reg;

  assign in_ready = rst && (count_q <= CW'(DEPTH - 2));
  assign pending  = count_q;

  always_comb begin
    accept     = in_valid && in_ready;
    acc0       = accept && in_we0;
    acc1       = accept && in_we1;
    n_acc      = {1'b0, acc0} + {1'b0, acc1};
    // Accepted entries compacted: 'first' is the oldest accepted write, 'second' exists only
    // for a dual write and is always slot 1.
    first      = acc0 ? {in_addr0, in_data0} : {in_addr1, in_data1};
    second     = {in_addr1, in_data1};
    fifo_empty = (count_q == '0);
`ifdef WB_BYPASS_EN
    // Also require no registered write this cycle so the port never carries two writes.
    bypass     = fifo_empty && !we_q && (n_acc != 2'd0);
`else
    bypass     = 1'b0;
`endif
    pop_fifo = 1'b0;
    pop_reg  = 1'b0;
    head     = mem_q[rd_ptr_q];
    st_n     = 2'd0;
    st_a     = first;
    st_b     = second;
    if (bypass) begin
      // 'first' leaves combinationally; only slot 1 of a dual write is stored.
      st_n = n_acc - 2'd1;
      st_a = second;
    end else if (fifo_empty) begin
      // Head of the virtual queue is this edge's first accepted write.
      pop_reg = (n_acc != 2'd0);
      head    = first;
      st_n    = (n_acc == 2'd2) ? 2'd1 : 2'd0;
      st_a    = second;
    end else begin
      pop_reg  = 1'b1;
      pop_fifo = 1'b1;
      st_n     = n_acc;
    end
    wr_inc   = wr_ptr_q + PW'(1);
    count_d  = count_q + CW'(st_n) - CW'(pop_fifo);
    rd_ptr_d = rd_ptr_q + PW'(pop_fifo);
    wr_ptr_d = wr_ptr_q + PW'(st_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      we_q     <= pop_reg;
      if (pop_reg) begin
        addr_q <= head[EW-1:DATA_W];
        data_q <= head[DATA_W-1:0];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (st_n != 2'd0) mem_q[wr_ptr_q] <= st_a;
    if (st_n == 2'd2) mem_q[wr_inc]   <= st_b;
  end

  always_comb begin
    write_enable = we_q;
    WB_address   = addr_q;
    WB_data      = data_q;
`ifdef WB_BYPASS_EN
    if (bypass) begin
      write_enable = 1'b1;
      WB_address   = first[EW-1:DATA_W];
      WB_data      = first[DATA_W-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_wb_write_serializer.sv
module tb_wb_write_serializer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              in_we0, in_we1;
  logic [ADDR_W-1:0] in_addr0, in_addr1;
  logic [DATA_W-1:0] in_data0, in_data1;
  logic [DATA_W-1:0] WB_data;
  logic [ADDR_W-1:0] WB_address;
  logic              write_enable;
  logic [2:0]        pending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ADDR_W+DATA_W-1:0] log_q[$];
  int                       log_cyc[$];

  wb_write_serializer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_we0       (in_we0),
    .in_addr0     (in_addr0),
    .in_data0     (in_data0),
    .in_we1       (in_we1),
    .in_addr1     (in_addr1),
    .in_data1     (in_data1),
    .WB_data      (WB_data),
    .WB_address   (WB_address),
    .write_enable (write_enable),
    .pending      (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every issued register write with its cycle number.
  always @(negedge clk) begin
    if (write_enable) begin
      log_q.push_back({WB_address, WB_data});
      log_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                            input logic w1, input logic [2:0] a1, input logic [15:0] d1);
    in_valid = 1'b1;
    in_we0 = w0; in_addr0 = a0; in_data0 = d0;
    in_we1 = w1; in_addr1 = a1; in_data1 = d1;
  endtask

  // Hold the current bundle until an edge accepts it; notes in_ready=0 episodes.
  task automatic offer(output bit ok, inout bit saw_full);
    bit acc;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      acc = in_ready;
      if (!acc && !saw_full) begin
        saw_full = 1'b1;
        check_eq("bp_full_pending", 32'(pending), 32'd3);
      end
      step();
      if (acc) ok = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (pending != 0 || write_enable); i++) step();
    step();
    check_eq("drain_pending", 32'(pending), 32'd0);
    check_eq("drain_we", 32'(write_enable), 32'd0);
  endtask

  initial begin
    bit ok, saw_full;
    rst = 1'b0;
    set_bundle(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd6, 16'hEEEE);

    // Reset with in_valid held high.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we", 32'(write_enable), 32'd0);
    check_eq("rst_addr", 32'(WB_address), 32'd0);
    check_eq("rst_data", 32'(WB_data), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    step();

    // Single write.
    set_bundle(1'b1, 3'b010, 16'h112F, 1'b0, 3'd0, 16'h0000);
`ifdef WB_BYPASS_EN
    #1;
    check_eq("single_byp_we", 32'(write_enable), 32'd1);
    check_eq("single_byp_addr", 32'(WB_address), 32'd2);
    check_eq("single_byp_data", 32'(WB_data), 32'h112F);
    step();
    in_valid = 1'b0;
    check_eq("single_byp_we_after", 32'(write_enable), 32'd0);
`else
    step();
    in_valid = 1'b0;
    check_eq("single_we", 32'(write_enable), 32'd1);
    check_eq("single_addr", 32'(WB_address), 32'd2);
    check_eq("single_data", 32'(WB_data), 32'h112F);
    check_eq("single_pending", 32'(pending), 32'd0);
    step();
    check_eq("single_we_off", 32'(write_enable), 32'd0);
    check_eq("single_addr_hold", 32'(WB_address), 32'd2);
    check_eq("single_data_hold", 32'(WB_data), 32'h112F);
`endif
    step();

    // Dual write (SWAP).
    log_q.delete(); log_cyc.delete();
    set_bundle(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    step();
    in_valid = 1'b0;
    check_eq("dual_pending_peak", 32'(pending), 32'd1);
    drain();
    check_eq("dual_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check_eq("dual_w0", 32'(log_q[0]), {13'd0, 3'd1, 16'hAAAA});
      check_eq("dual_w1", 32'(log_q[1]), {13'd0, 3'd2, 16'h5555});
      check_eq("dual_consec", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    end

    // Backpressure: four dual bundles carrying addresses 0..7.
    log_q.delete(); log_cyc.delete();
    saw_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_bundle(1'b1, 3'(2 * k), 16'hB000 + 16'(2 * k),
                 1'b1, 3'(2 * k + 1), 16'hB000 + 16'(2 * k + 1));
      offer(ok, saw_full);
      check_eq("bp_accepted", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
    check_eq("bp_saw_full", 32'(saw_full), 32'd1);
    drain();
    check_eq("bp_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check_eq($sformatf("bp_w%0d", i), 32'(log_q[i]), {13'd0, 3'(i), 16'hB000 + 16'(i)});
`ifndef WB_BYPASS_EN
      if (i > 0) check_eq($sformatf("bp_consec%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
`endif
    end

    // Same address in both slots: slot 1 lands last.
    log_q.delete(); log_cyc.delete();
    set_bundle(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002);
    step();
    in_valid = 1'b0;
    drain();
    check_eq("same_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check_eq("same_w0", 32'(log_q[0]), {13'd0, 3'd5, 16'h0001});
      check_eq("same_w1", 32'(log_q[1]), {13'd0, 3'd5, 16'h0002});
    end

    // Reset mid-stream with two entries stored.
    set_bundle(1'b1, 3'd3, 16'hC001, 1'b1, 3'd4, 16'hC002);
    step();
    set_bundle(1'b1, 3'd5, 16'hC003, 1'b1, 3'd6, 16'hC004);
    step();
    in_valid = 1'b0;
    check_eq("mid_pending", 32'(pending), 32'd2);
    rst = 1'b0;
    step();
    check_eq("mid_rst_pending", 32'(pending), 32'd0);
    check_eq("mid_rst_we", 32'(write_enable), 32'd0);
    rst = 1'b1;
    log_q.delete(); log_cyc.delete();
    repeat (6) step();
    check_eq("mid_no_writes", 32'(log_q.size()), 32'd0);
    check_eq("mid_final_pending", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
